// File: rtl/reg_rom_pkg.sv
// Shared defaults, reset-time constant table and streamer state encoding.
package reg_rom_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 6;
    localparam int INIT_WORDS = 64;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [15:0] INIT_TABLE [0:INIT_WORDS-1] = '{
        16'hdcdc, 16'h34b2, 16'h8faa, 16'h0000, 16'h4e1d, 16'h91c3, 16'ha507, 16'h3f68,
        16'h6b2a, 16'hc0d9, 16'h17e4, 16'h5f31, 16'he88c, 16'h2d45, 16'hb9f0, 16'h0473,
        16'h78f6, 16'hc35a, 16'h9e01, 16'h41bd, 16'h5a27, 16'hf6c8, 16'h0d93, 16'ha34e,
        16'h12f5, 16'h8b6e, 16'he7a0, 16'h3c19, 16'hd4b7, 16'h6f82, 16'h205d, 16'h99ca,
        16'h5e3f, 16'hb014, 16'h07c6, 16'hfa79, 16'h4d20, 16'h81e3, 16'hc68b, 16'h3a54,
        16'he10f, 16'h7c92, 16'h2bd8, 16'h956d, 16'h0fa1, 16'hd83c, 16'h64e7, 16'ha97b,
        16'h2b7e, 16'h1516, 16'h28ae, 16'hd2a6, 16'habf7, 16'h1588, 16'h09cf, 16'h4f3c,
        16'h8e73, 16'hf0b9, 16'h36d4, 16'hc125, 16'h5b8a, 16'h97e2, 16'hb663, 16'h0ca6
    };

    // Default contents of word idx; storage deeper than the table resets to zero.
    function automatic logic [15:0] init_word(input int unsigned idx);
        if (idx < INIT_WORDS) begin
            return INIT_TABLE[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/reg_rom_stream_seq.sv
// Burst streamer: FSM, pointer/remaining counters and valid/ready output registers.
module reg_rom_stream_seq
    import reg_rom_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [DATA_W-1:0] fetch_data,
    output logic              burst_busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic [LEN_W-1:0]    rem;
    logic [LEN_W-1:0]    rem_nxt;
    logic                valid_nxt;
    logic                last_nxt;
    logic                busy_nxt;
    logic [DATA_W-1:0]   data_nxt;

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            rem        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            burst_busy <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            rem        <= rem_nxt;
            out_valid  <= valid_nxt;
            out_last   <= last_nxt;
            burst_busy <= busy_nxt;
            out_data   <= data_nxt;
        end
    end

    // Next-state logic; the fetch address always points at the word to load on this edge.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        rem_nxt    = rem;
        valid_nxt  = out_valid;
        last_nxt   = out_last;
        busy_nxt   = burst_busy;
        data_nxt   = out_data;
        fetch_addr = ptr + ADDR_W'(1);
        unique case (state)
            IDLE: begin
                fetch_addr = burst_addr;
                if (burst_start && (burst_len != '0)) begin
                    ptr_nxt   = burst_addr;
                    rem_nxt   = burst_len;
                    data_nxt  = fetch_data;
                    valid_nxt = 1'b1;
                    last_nxt  = (burst_len == LEN_W'(1));
                    busy_nxt  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (!out_last) begin
                        ptr_nxt  = ptr + ADDR_W'(1);
                        rem_nxt  = rem - LEN_W'(1);
                        data_nxt = fetch_data;
                        last_nxt = (rem == LEN_W'(2));
                    end else begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/reg_rom_stream.sv
// Reset-initialised word store with legacy read port, patch port and burst streamer.
module reg_rom_stream
    import reg_rom_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              CEN,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Q,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              burst_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;

    // Storage: reset reloads the constant table; writes land at the edge so
    // same-cycle readers see the previous word.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(init_word(i));
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // Legacy registered read, enabled by active-low CEN.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            Q <= '0;
        end else if (!CEN) begin
            Q <= mem[A];
        end
    end

    assign fetch_data = mem[fetch_addr];

    reg_rom_stream_seq #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_seq (
        .clk        (CLK),
        .rst        (rst),
        .burst_start(burst_start),
        .burst_addr (burst_addr),
        .burst_len  (burst_len),
        .out_ready  (out_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .burst_busy (burst_busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last)
    );

endmodule

// File: tb/tb_reg_rom_stream.sv
// Self-checking bench for reg_rom_stream: read-vector table plus stream scoreboard.
module tb_reg_rom_stream;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 7;

    logic              CLK = 1'b0;
    logic              rst;
    logic              CEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Q;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              burst_start;
    logic [ADDR_W-1:0] burst_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              burst_busy;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    reg_rom_stream #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .CEN        (CEN),
        .A          (A),
        .Q          (Q),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .burst_start(burst_start),
        .burst_addr (burst_addr),
        .burst_len  (burst_len),
        .burst_busy (burst_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              cen;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] q;
    } rd_vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  errors   = 0;
    int  hs_count = 0;

    logic              stall_seen = 1'b0;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int unsigned i);
        return (DATA_W'(i) * 16'h0101) ^ 16'h5a5a;
    endfunction

    task automatic push(input logic [DATA_W-1:0] d, input logic l);
        sb_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    // Stream monitor: sampled mid-cycle, so it sees what the next edge will consume.
    always @(negedge CLK) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(stall_data));
                chk("stall_last", 32'(out_last), 32'(stall_last));
            end
            if (out_valid && out_ready) begin
                sb_t e;
                hs_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("stream_data", 32'(out_data), 32'(e.data));
                    chk("stream_last", 32'(out_last), 32'(e.last));
                end
            end
            stall_seen = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_vec_t rd_tab [10];
        logic    ready_pat [5];
        int      hs0;

        rd_tab[0] = '{1'b0, 6'd0,  16'hdcdc};
        rd_tab[1] = '{1'b0, 6'd1,  16'h34b2};
        rd_tab[2] = '{1'b0, 6'd2,  16'h8faa};
        rd_tab[3] = '{1'b1, 6'd5,  16'h8faa};
        rd_tab[4] = '{1'b1, 6'd0,  16'h8faa};
        rd_tab[5] = '{1'b0, 6'd3,  16'h0000};
        rd_tab[6] = '{1'b0, 6'd16, 16'h78f6};
        rd_tab[7] = '{1'b0, 6'd48, 16'h2b7e};
        rd_tab[8] = '{1'b0, 6'd62, 16'hb663};
        rd_tab[9] = '{1'b0, 6'd63, 16'h0ca6};
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; CEN = 1'b1; A = '0; we = 1'b0; wa = '0; wd = '0;
        burst_start = 1'b0; burst_addr = '0; burst_len = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(burst_busy), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        tick();

        // Legacy read vectors
        for (int i = 0; i < 10; i++) begin
            CEN = rd_tab[i].cen;
            A   = rd_tab[i].a;
            tick();
            chk("legacy_q", 32'(Q), 32'(rd_tab[i].q));
        end
        CEN = 1'b1;

        // Wrapping burst 62..1 at full throughput
        out_ready = 1'b1;
        push(16'hb663, 1'b0); push(16'h0ca6, 1'b0); push(16'hdcdc, 1'b0); push(16'h34b2, 1'b1);
        burst_start = 1'b1; burst_addr = 6'd62; burst_len = 7'd4;
        tick();
        burst_start = 1'b0;
        chk("b1_busy_start", 32'(burst_busy), 32'd1);
        chk("b1_first", 32'(out_data), 32'hb663);
        tick(); tick(); tick();
        chk("b1_busy_mid", 32'(burst_busy), 32'd1);
        tick();
        chk("b1_busy_end", 32'(burst_busy), 32'd0);
        chk("b1_queue", 32'(sb.size()), 32'd0);
        tick();

        // Burst with backpressure
        hs0 = hs_count;
        push(16'h2b7e, 1'b0); push(16'h1516, 1'b0); push(16'h28ae, 1'b1);
        out_ready = 1'b0;
        burst_start = 1'b1; burst_addr = 6'd48; burst_len = 7'd3;
        tick();
        burst_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            out_ready = ready_pat[k];
            tick();
        end
        chk("b2_busy_end", 32'(burst_busy), 32'd0);
        chk("b2_handshakes", 32'(hs_count - hs0), 32'd3);
        chk("b2_queue", 32'(sb.size()), 32'd0);

        // Write vs same-cycle read, then reset restores the table
        we = 1'b1; wa = 6'd1; wd = 16'haaaa; CEN = 1'b0; A = 6'd1;
        tick();
        we = 1'b0;
        chk("wr_old", 32'(Q), 32'h34b2);
        tick();
        chk("wr_new", 32'(Q), 32'haaaa);
        CEN = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wr_rst_q", 32'(Q), 32'h0);
        CEN = 1'b0; A = 6'd1;
        tick();
        chk("wr_restored", 32'(Q), 32'h34b2);
        CEN = 1'b1;

        // Zero-length request is ignored
        burst_start = 1'b1; burst_addr = 6'd5; burst_len = 7'd0;
        tick();
        burst_start = 1'b0;
        chk("len0_busy", 32'(burst_busy), 32'd0);
        chk("len0_valid", 32'(out_valid), 32'd0);
        tick();
        chk("len0_busy2", 32'(burst_busy), 32'd0);

        // Request during STREAM is dropped
        hs0 = hs_count;
        out_ready = 1'b0;
        push(16'h2b7e, 1'b0); push(16'h1516, 1'b1);
        burst_start = 1'b1; burst_addr = 6'd48; burst_len = 7'd2;
        tick();
        burst_addr = 6'd62; burst_len = 7'd4;
        tick();
        burst_start = 1'b0;
        chk("busy_ignore_data", 32'(out_data), 32'h2b7e);
        out_ready = 1'b1;
        drain("ignore", 20);
        tick(); tick();
        chk("ignore_handshakes", 32'(hs_count - hs0), 32'd2);
        chk("ignore_idle", 32'(burst_busy), 32'd0);

        // Patch words 1..63, then a 65-word burst wraps onto word 0
        for (int i = 1; i < 64; i++) begin
            we = 1'b1; wa = ADDR_W'(i); wd = pat(i);
            tick();
        end
        we = 1'b0;
        hs0 = hs_count;
        for (int k = 0; k < 65; k++) begin
            if (k % 64 == 0) push(16'hdcdc, (k == 64));
            else push(pat(k % 64), 1'b0);
        end
        burst_start = 1'b1; burst_addr = 6'd0; burst_len = 7'd65;
        tick();
        burst_start = 1'b0;
        drain("len65", 100);
        chk("len65_handshakes", 32'(hs_count - hs0), 32'd65);
        chk("len65_hold_data", 32'(out_data), 32'hdcdc);
        chk("len65_busy", 32'(burst_busy), 32'd0);
        tick();

        // Reset mid-burst
        hs0 = hs_count;
        out_ready = 1'b0;
        push(pat(16), 1'b0); push(pat(17), 1'b0);
        burst_start = 1'b1; burst_addr = 6'd16; burst_len = 7'd5;
        tick();
        burst_start = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("abort_handshakes", 32'(hs_count - hs0), 32'd2);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(burst_busy), 32'd0);
        chk("abort_data", 32'(out_data), 32'h0);
        tick();
        rst = 1'b0;
        sb.delete();
        push(16'h78f6, 1'b1);
        out_ready = 1'b1;
        burst_start = 1'b1; burst_addr = 6'd16; burst_len = 7'd1;
        tick();
        burst_start = 1'b0;
        chk("after_abort_first", 32'(out_data), 32'h78f6);
        drain("after_abort", 10);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_rom_stream.md
Name: reg_rom_stream

Overview:
- Parametrised successor to the 64x16 reset-initialised constant store used by the ECC datapath.
- Keeps the legacy single-word read port (CEN active-low, registered Q).
- Adds a runtime write/patch port and a burst-read streamer with a valid/ready output handshake, so key and constant tables can be streamed into downstream engines without per-word address sequencing.

Parameters:
- DATA_W, 16: word width.
- ADDR_W, 6: address width; DEPTH = 2**ADDR_W words.
- LEN_W, ADDR_W+1: burst length field width.

Ports:
- CLK  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- CEN  in  1  legacy read enable, active-low
- A  in  ADDR_W  legacy read address
- Q  out  DATA_W  legacy registered read data
- we  in  1  write enable, active-high
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- burst_start  in  1  single-cycle burst request
- burst_addr  in  ADDR_W  burst start address
- burst_len  in  LEN_W  burst word count
- burst_busy  out  1  streamer active
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts word
- out_data  out  DATA_W  stream word
- out_last  out  1  final word of burst

Behaviour:
- Reset is asynchronous and active-high.
  - Storage loads the package INIT table (word i = INIT(i)).
  - Q=0, out_valid=0, out_data=0, out_last=0, burst_busy=0, FSM=IDLE.
  - Reset asserted mid-burst aborts the burst and reloads INIT; patched words are lost.
- Legacy port:
  - CEN=0 at a CLK edge gives Q = mem[A] after that edge (1-cycle latency).
  - CEN=1 holds Q.
  - Independent of the streamer; both may read in the same cycle.
- Write:
  - we=1 at an edge sets mem[wa] <= wd.
  - A read of the same address in the same cycle (legacy or streamer fetch) returns the OLD word.
  - The new value is visible from the next cycle.
- Streamer FSM, two states:
  - IDLE:
    - burst_start=1 with burst_len!=0 latches ptr=burst_addr, rem=burst_len.
    - Same edge: out_data <= mem[burst_addr], out_valid <= 1, out_last <= (burst_len==1), burst_busy <= 1, go to STREAM.
    - burst_len==0 is ignored; the FSM stays in IDLE.
  - STREAM:
    - out_valid && !out_ready: out_data, out_valid and out_last hold stable (AXI-style; no change while stalled).
    - out_valid && out_ready && !out_last: ptr <= ptr+1 mod DEPTH (DEPTH-1 wraps to 0), rem <= rem-1; fetch the next word into out_data the same edge; out_last <= (rem==2). Throughput is 1 word/cycle while out_ready=1.
    - out_valid && out_ready && out_last: out_valid <= 0, out_last <= 0, burst_busy <= 0, go to IDLE. out_data holds its last value.
    - burst_start while in STREAM is ignored; there is no queueing.
- Burst lengths above DEPTH are legal; addresses wrap and words repeat.
- Words are fetched at hand-off time: a write to a not-yet-fetched address inside the burst is streamed with its new value.
- A new burst may be accepted the cycle after the final handshake (1 idle cycle minimum).

Decomposition:
- Package reg_rom_pkg holds:
  - default DATA_W/ADDR_W;
  - INIT function returning the 64-entry default table (dcdc, 34b2, 8faa, 0000, ... 0ca6), with 0 beyond index 63 for larger depths;
  - state enum {IDLE, STREAM}.
- Sub-module reg_rom_stream_seq holds the FSM, ptr/rem counters and handshake regs. It drives the fetch address and takes the fetched word from the top-level array.

Test Plan:
1. Reset then CEN=0, A=0,1,2 on consecutive cycles -> Q=dcdc,34b2,8faa one cycle after each; CEN=1 -> Q holds 8faa.
2. burst_start, addr=62, len=4, out_ready=1 -> out_data b663,0ca6,dcdc,34b2 on 4 consecutive cycles; out_last only on 34b2; burst_busy falls after it.
3. burst addr=48, len=3, out_ready toggled 1,0,0,1,1 -> stream 2b7e,1516,28ae with each word stable during stalls; exactly 3 handshakes.
4. we=1, wa=1, wd=aaaa while CEN=0, A=1 -> Q=34b2; next read -> aaaa. Then assert rst -> read A=1 gives 34b2.
5. Corner requests -> len=0 is ignored (busy stays 0); burst_start during STREAM is ignored; len=65 from 0 -> 65 words ending with dcdc, out_last on word 65.
6. rst pulsed mid-burst (after 2 words) -> out_valid=0, burst_busy=0 immediately; the next burst from 16 returns 78f6.
